spi_chip_responder: RTL and testbench
=====================================

# spi_chip_responder

Chip-side SPI responder: the other end of the FPGA's SPI link to the electrochemical front-end ASIC. It generates the serial clock seen by the FPGA as `SPI_CLK_OUT` while `CS_B` is low, shifts `MOSI` into config (64-bit) or waveform (32-bit) frames selected by `SPI_SEL`, and returns the previous register contents on `MISO`. It is used as an ASIC stand-in for FPGA loopback bring-up and as the bench model for the SPI control path.

## Interface
- `CLK_DIV`, 4: `spi_clk_out` half-period in `clk` cycles; legal range is ≥4.
- `CFG_BITS`, 64: config frame length.
- `WAV_BITS`, 32: waveform frame length.
- `CFG_RESET`, 64'h0: reset value of `cfg_reg`.

- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cs_b`  in  1  chip select, active low, asynchronous to `clk`.
- `spi_sel`  in  1  frame type: 1 = config, 0 = waveform.
- `mosi`  in  1  serial data from the master, MSB first.
- `spi_clk_out`  out  1  generated serial clock.
- `miso`  out  1  readback data, MSB first.
- `cfg_reg`  out  64  committed config register.
- `cfg_valid`  out  1  one-cycle pulse when `cfg_reg` updates.
- `wav_word`  out  32  committed waveform (DAC) word.
- `wav_valid`  out  1  one-cycle pulse when `wav_word` updates.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `cs_b`, `spi_sel` and `mosi` each pass through a 2-FF synchronizer, producing `*_s`. A falling edge of `cs_b_s` is detected against a registered copy.
- The FSM has five states: IDLE, SETUP, HIGH, LOW, DONE. A divider counter runs 0..CLK_DIV-1.
- **IDLE**
  - Outputs: `spi_clk_out` = 0, `miso` = 0.
  - On a `cs_b_s` falling edge:
    - latch `sel_q` ← `spi_sel_s`;
    - load `tx` ← `cfg_reg` when `sel_q` = 1, else {32'h0, `wav_word`};
    - load `bitcnt` ← CFG_BITS or WAV_BITS;
    - go to SETUP.
- **SETUP**
  - `miso` = MSB of the active frame width in `tx`.
  - Lasts CLK_DIV cycles, then go to HIGH.
- **HIGH**
  - `spi_clk_out` = 1 for CLK_DIV cycles.
  - On the last cycle, `rx` ← {`rx`, `mosi_s`}, then go to LOW.
- **LOW**
  - `spi_clk_out` = 0 for CLK_DIV cycles.
  - On the first cycle, `tx` shifts left and `miso` presents the next bit.
  - On the last cycle, `bitcnt` decrements. Go to HIGH if `bitcnt` ≠ 0 after the decrement, else go to DONE.
- **DONE**, entered with commit in the same cycle:
  - `sel_q` = 1: `cfg_reg` ← `rx[63:0]`, `cfg_valid` pulses.
  - `sel_q` = 0: `wav_word` ← `rx[31:0]`, `wav_valid` pulses.
  - Stay in DONE with `spi_clk_out` = 0 until `cs_b_s` = 1, then go to IDLE.
- **Abort:** `cs_b_s` = 1 in SETUP, HIGH or LOW.
  - Go to IDLE next cycle.
  - `frame_err` pulses.
  - No commit; `cfg_reg` and `wav_word` hold.
- Changes on `spi_sel` after the frame starts are ignored (`sel_q` is latched).
- Holding `cs_b` low after DONE generates no further clocks. A new frame requires `cs_b` to go high, then low.
- Unused upper `rx` bits in waveform frames are don't-care.

## Timing
- Reset values:
  - `spi_clk_out`, `miso`, `cfg_valid`, `wav_valid`, `frame_err`, `busy` = 0;
  - `cfg_reg` = CFG_RESET;
  - `wav_word` = 0;
  - state = IDLE.
- `rst_n` low mid-frame forces these immediately (asynchronously); the frame is lost and `frame_err` is not pulsed.
- Start latency: `cs_b` pin fall to SETUP entry is 3 `clk` cycles (2 synchronizer stages plus edge detect).
- Frame length:
  - CLK_DIV + 2·N·CLK_DIV cycles from SETUP entry to DONE entry, where N = CFG_BITS or WAV_BITS.
  - `cfg_valid`/`wav_valid` rise on the DONE entry cycle.
- Sample point: `mosi_s` is sampled CLK_DIV-1 cycles after the `spi_clk_out` rising edge. The master must update `mosi` on the rising edge; CLK_DIV ≥ 4 covers synchronizer delay.
- `miso` is stable from the `spi_clk_out` falling edge to the next falling edge.
- Abort detection: `spi_clk_out` is low within 3 cycles of the `cs_b` pin rising.

## Structure
- Package `spi_resp_pkg` holds:
  - the state enum (IDLE/SETUP/HIGH/LOW/DONE);
  - constants CFG_BITS_DEF = 64, WAV_BITS_DEF = 32;
  - the bit-counter width localparam (7 bits).
- One sub-module: `bit_sync`, a 2-FF synchronizer with an asynchronous active-low reset. It is instantiated three times (`cs_b` and `spi_sel` reset to 1 and 0 as appropriate, `mosi` to 0).

## Test plan
All scenarios use CLK_DIV = 4.
- Config frame, `spi_sel` = 1, MOSI 64'hDEAD_BEEF_0123_4567:
  - exactly 64 `spi_clk_out` rising edges;
  - `cfg_reg` = 64'hDEAD_BEEF_0123_4567;
  - one `cfg_valid` pulse at cycle 3+4+512 from the `cs_b` fall;
  - `miso` stream all zero.
- Second config frame, MOSI 64'h1:
  - `miso` returns 64'hDEAD_BEEF_0123_4567, MSB first;
  - `cfg_reg` = 64'h1.
- Waveform frame, `spi_sel` = 0, MOSI 32'hA5A5_0F0F:
  - 32 edges;
  - `wav_word` = 32'hA5A5_0F0F;
  - one `wav_valid` pulse;
  - `cfg_reg` unchanged;
  - `spi_sel` toggled at bit 5 has no effect.
- Abort: `cs_b` raised after 10 bits of a config frame:
  - `frame_err` pulses once;
  - no valid pulse;
  - `cfg_reg` unchanged;
  - `spi_clk_out` low within 3 cycles.
- `rst_n` low at bit 20:
  - all outputs take reset values immediately;
  - `cfg_reg` = CFG_RESET;
  - the next full frame completes normally.
- `cs_b` held low 200 cycles after DONE: no extra `spi_clk_out` edges and `busy` stays high; after `cs_b` rises, `busy` = 0 within 3 cycles.

Source files
------------

// File: rtl/spi_resp_pkg.sv
// spi_resp_pkg: shared state encoding and frame constants for the SPI chip responder
package spi_resp_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;
  localparam int CFG_BITS_DEF = 64;
  localparam int WAV_BITS_DEF = 32;
  localparam int CNT_W = 7;
endpackage

// File: rtl/spi_chip_responder_bit_sync.sv
// bit_sync: two-flop synchronizer with asynchronous active-low reset to a chosen idle value
module bit_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  // two-stage capture of an input that is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end
  assign o_q = r_q;
endmodule

// File: rtl/spi_chip_responder.sv
// spi_chip_responder: ASIC-side SPI stand-in generating the serial clock and shifting config/waveform frames
module spi_chip_responder
  import spi_resp_pkg::*;
#(
  parameter int                  CLK_DIV   = 4,
  parameter int                  CFG_BITS  = CFG_BITS_DEF,
  parameter int                  WAV_BITS  = WAV_BITS_DEF,
  parameter logic [CFG_BITS-1:0] CFG_RESET = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs_b,
  input  logic                spi_sel,
  input  logic                mosi,
  output logic                spi_clk_out,
  output logic                miso,
  output logic [CFG_BITS-1:0] cfg_reg,
  output logic                cfg_valid,
  output logic [WAV_BITS-1:0] wav_word,
  output logic                wav_valid,
  output logic                frame_err,
  output logic                busy
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic                cs_b_s, spi_sel_s, mosi_s;
  logic                r_cs_q;
  state_t              r_state, w_nxt;
  logic [DW-1:0]       r_div;
  logic [CNT_W-1:0]    r_bitcnt;
  logic                r_sel;
  logic [CFG_BITS-1:0] r_tx, r_rx, r_cfg;
  logic [WAV_BITS-1:0] r_wav;
  logic                r_sclk, r_busy, r_cfg_valid, r_wav_valid, r_frame_err;
  logic                w_cs_fall, w_run, w_div_last, w_last_bit, w_abort, w_shift, w_commit;

  bit_sync #(.RST_VAL(1'b1)) u_sync_cs  (.clk(clk), .rst_n(rst_n), .i_d(cs_b),    .o_q(cs_b_s));
  bit_sync #(.RST_VAL(1'b0)) u_sync_sel (.clk(clk), .rst_n(rst_n), .i_d(spi_sel), .o_q(spi_sel_s));
  bit_sync #(.RST_VAL(1'b0)) u_sync_mo  (.clk(clk), .rst_n(rst_n), .i_d(mosi),    .o_q(mosi_s));

  assign w_cs_fall  = r_cs_q & ~cs_b_s;
  assign w_run      = (r_state == SETUP) || (r_state == HIGH) || (r_state == LOW);
  assign w_div_last = (r_div == DW'(CLK_DIV - 1));
  assign w_last_bit = (r_bitcnt == CNT_W'(1));
  assign w_abort    = w_run && cs_b_s;
  assign w_shift    = (r_state == HIGH) && w_div_last && !cs_b_s;
  assign w_commit   = (r_state == LOW) && w_div_last && w_last_bit && !cs_b_s;

  // next state: a raised chip select in any shifting state aborts straight to IDLE
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = w_cs_fall ? SETUP : IDLE;
      SETUP:   w_nxt = cs_b_s ? IDLE : (w_div_last ? HIGH : SETUP);
      HIGH:    w_nxt = cs_b_s ? IDLE : (w_div_last ? LOW : HIGH);
      LOW:     w_nxt = cs_b_s ? IDLE : (w_div_last ? (w_last_bit ? DONE : HIGH) : LOW);
      DONE:    w_nxt = cs_b_s ? IDLE : DONE;
      default: w_nxt = IDLE;
    endcase
  end

  // state, divider and edge-detect registers; divider restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_cs_q  <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_div   <= (w_run && w_nxt == r_state) ? r_div + 1'b1 : '0;
      r_cs_q  <= cs_b_s;
    end
  end

  // serial clock, busy and pulses are registered from next state so they are glitch-free and track the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk      <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_valid <= 1'b0;
      r_wav_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sclk      <= (w_nxt == HIGH);
      r_busy      <= (w_nxt != IDLE);
      r_cfg_valid <= w_commit && r_sel;
      r_wav_valid <= w_commit && !r_sel;
      r_frame_err <= w_abort;
    end
  end

  // frame datapath: load readback on start, shift at the end of each high phase, commit on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel    <= 1'b0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_bitcnt <= '0;
      r_cfg    <= CFG_RESET;
      r_wav    <= '0;
    end else begin
      if (r_state == IDLE && w_cs_fall) begin
        r_sel    <= spi_sel_s;
        r_tx     <= spi_sel_s ? r_cfg : {{(CFG_BITS - WAV_BITS){1'b0}}, r_wav};
        r_bitcnt <= spi_sel_s ? CNT_W'(CFG_BITS) : CNT_W'(WAV_BITS);
      end
      if (w_shift) begin
        r_rx <= {r_rx[CFG_BITS-2:0], mosi_s};
        r_tx <= r_tx << 1;
      end
      if (r_state == LOW && w_div_last) r_bitcnt <= r_bitcnt - 1'b1;
      if (w_commit && r_sel) r_cfg <= r_rx;
      if (w_commit && !r_sel) r_wav <= r_rx[WAV_BITS-1:0];
    end
  end

  assign miso        = w_run && (r_sel ? r_tx[CFG_BITS-1] : r_tx[WAV_BITS-1]);
  assign spi_clk_out = r_sclk;
  assign busy        = r_busy;
  assign cfg_reg     = r_cfg;
  assign cfg_valid   = r_cfg_valid;
  assign wav_word    = r_wav;
  assign wav_valid   = r_wav_valid;
  assign frame_err   = r_frame_err;
endmodule

// File: tb/tb_spi_chip_responder.sv
// tb_spi_chip_responder: directed table-driven bench acting as SPI master against the responder
module tb_spi_chip_responder;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cs_b = 1'b1;
  logic        spi_sel = 1'b0;
  logic        mosi = 1'b0;
  logic        spi_clk_out, miso, cfg_valid, wav_valid, frame_err, busy;
  logic [63:0] cfg_reg;
  logic [31:0] wav_word;

  spi_chip_responder #(.CLK_DIV(DIV), .CFG_BITS(64), .WAV_BITS(32), .CFG_RESET(64'h0)) dut (
    .clk(clk), .rst_n(rst_n), .cs_b(cs_b), .spi_sel(spi_sel), .mosi(mosi),
    .spi_clk_out(spi_clk_out), .miso(miso), .cfg_reg(cfg_reg), .cfg_valid(cfg_valid),
    .wav_word(wav_word), .wav_valid(wav_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [63:0] data;
    int          nbits;
    int          stop_bit;
    logic [63:0] e_cfg;
    logic [31:0] e_wav;
    logic [63:0] e_rd;
    int          e_edges;
    int          e_cv;
    int          e_wv;
    int          e_fe;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          edges, n_cv, n_wv, n_fe, v_cyc, busy_low, busy_rel;
  logic        sclk_ab;
  logic [63:0] rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    check({p, "_sclk"}, 64'(spi_clk_out), 64'd0);
    check({p, "_miso"}, 64'(miso), 64'd0);
    check({p, "_cfg_valid"}, 64'(cfg_valid), 64'd0);
    check({p, "_wav_valid"}, 64'(wav_valid), 64'd0);
    check({p, "_frame_err"}, 64'(frame_err), 64'd0);
    check({p, "_busy"}, 64'(busy), 64'd0);
    check({p, "_cfg_reg"}, cfg_reg, 64'h0);
    check({p, "_wav_word"}, 64'(wav_word), 64'd0);
  endtask

  // Acts as master: drops cs_b, drives mosi MSB first on each serial-clock rise, collects miso.
  task automatic run_frame(input logic sel, input logic [63:0] data, input int nbits,
                           input int stop_bit, input int rst_bit, input int hold);
    int   lim, ab;
    logic prev;
    edges = 0; n_cv = 0; n_wv = 0; n_fe = 0; v_cyc = -1; busy_low = 0; busy_rel = -1;
    sclk_ab = 1'bx; rd = '0; prev = 1'b0; ab = -1;
    @(negedge clk);
    cs_b = 1'b0;
    spi_sel = sel;
    lim = 3 + DIV + 2 * nbits * DIV + hold;
    for (int cyc = 1; cyc <= lim; cyc++) begin
      @(negedge clk);
      if (spi_clk_out && !prev) begin
        edges++;
        rd = {rd[62:0], miso};
        if (edges <= nbits) mosi = data[nbits-edges];
        if (edges == 5) spi_sel = ~spi_sel;
      end
      prev = spi_clk_out;
      if (cfg_valid) begin n_cv++; v_cyc = cyc; end
      if (wav_valid) begin n_wv++; v_cyc = cyc; end
      if (frame_err) n_fe++;
      if (v_cyc > 0 && cyc > v_cyc && !busy) busy_low++;
      if (ab > 0 && cyc == ab + 3) sclk_ab = spi_clk_out;
      if (ab < 0 && stop_bit > 0 && edges == stop_bit) begin
        cs_b = 1'b1;
        ab = cyc;
        lim = cyc + 10;
      end
      if (rst_bit > 0 && edges == rst_bit) begin
        rst_n = 1'b0;
        cs_b = 1'b1;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
    if (ab < 0 && rst_bit == 0) begin
      cs_b = 1'b1;
      repeat (3) @(negedge clk);
      busy_rel = int'(busy);
    end
    mosi = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{1'b1, 64'hDEAD_BEEF_0123_4567, 64, 0, 64'hDEAD_BEEF_0123_4567, 32'h0, 64'h0, 64, 1, 0, 0};
    tbl[1] = '{1'b1, 64'h1, 64, 0, 64'h1, 32'h0, 64'hDEAD_BEEF_0123_4567, 64, 1, 0, 0};
    tbl[2] = '{1'b0, 64'hA5A5_0F0F, 32, 0, 64'h1, 32'hA5A5_0F0F, 64'h0, 32, 0, 1, 0};
    tbl[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64, 10, 64'h1, 32'hA5A5_0F0F, 64'h0, 10, 0, 0, 1};
    tbl[4] = '{1'b0, 64'h1234_5678, 32, 0, 64'h1, 32'h1234_5678, 64'hA5A5_0F0F, 32, 0, 1, 0};

    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].sel, tbl[i].data, tbl[i].nbits, tbl[i].stop_bit, 0, 5);
      check($sformatf("v%0d_edges", i), 64'(edges), 64'(tbl[i].e_edges));
      check($sformatf("v%0d_miso", i), rd, tbl[i].e_rd);
      check($sformatf("v%0d_cfg_reg", i), cfg_reg, tbl[i].e_cfg);
      check($sformatf("v%0d_wav_word", i), 64'(wav_word), 64'(tbl[i].e_wav));
      check($sformatf("v%0d_cfg_valid_n", i), 64'(n_cv), 64'(tbl[i].e_cv));
      check($sformatf("v%0d_wav_valid_n", i), 64'(n_wv), 64'(tbl[i].e_wv));
      check($sformatf("v%0d_frame_err_n", i), 64'(n_fe), 64'(tbl[i].e_fe));
      if (tbl[i].stop_bit == 0) begin
        check($sformatf("v%0d_valid_cycle", i), 64'(v_cyc), 64'(3 + DIV + 2 * tbl[i].nbits * DIV));
        check($sformatf("v%0d_busy_done", i), 64'(busy_low), 64'd0);
        check($sformatf("v%0d_busy_release", i), 64'(busy_rel), 64'd0);
      end else begin
        check($sformatf("v%0d_sclk_abort", i), 64'(sclk_ab), 64'd0);
      end
    end

    run_frame(1'b1, 64'hCAFE_F00D_1234_5678, 64, 0, 20, 0);
    check("rst_edges", 64'(edges), 64'd20);
    check("rst_no_err_in_frame", 64'(n_fe), 64'd0);
    n_fe = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (frame_err || cfg_valid || wav_valid || spi_clk_out) n_fe++;
    end
    check("rst_quiet_after", 64'(n_fe), 64'd0);
    check("rst_cfg_reg", cfg_reg, 64'h0);

    run_frame(1'b1, 64'h0123_4567_89AB_CDEF, 64, 0, 0, 200);
    check("post_edges", 64'(edges), 64'd64);
    check("post_cfg_reg", cfg_reg, 64'h0123_4567_89AB_CDEF);
    check("post_miso", rd, 64'h0);
    check("post_cfg_valid_n", 64'(n_cv), 64'd1);
    check("post_valid_cycle", 64'(v_cyc), 64'(3 + DIV + 2 * 64 * DIV));
    check("hold_busy_high", 64'(busy_low), 64'd0);
    check("hold_busy_release", 64'(busy_rel), 64'd0);
    check("hold_wav_word", 64'(wav_word), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
